morse_rx_param: RTL and testbench
=================================

Name: morse_rx_param

Overview:
Parametrised successor to the Morse receiver FSM. It takes the debounced button level and classifies presses as dot, dash, glitch or abort, and gaps as intra-char, char-end or word-end. All timing comes from internal counters, so no external timer blocks are needed. Completed characters and word spaces leave through a one-entry valid/ready output register that feeds the character decoder.

Parameters:
UNIT_CYC, 5000000, clock cycles per Morse unit (50 ms at 100 MHz)
MIN_PRESS_CYC, 100000, presses shorter than this are glitches and are ignored
DASH_UNITS, 2, press >= DASH_UNITS*UNIT_CYC is a dash
ABORT_UNITS, 10, press >= ABORT_UNITS*UNIT_CYC aborts the current char
CHAR_GAP_UNITS, 3, gap that ends a char
WORD_GAP_UNITS, 7, gap that ends a word
MAX_SYMS, 6, symbol buffer depth (1..8)
EMIT_SPACE, 1, 1 = emit a space record on word gap
CNT_W, 32, width of both counters; must hold ABORT and WORD thresholds

Ports:
clk_100MHz  in  1  clock
reset_n  in  1  asynchronous active-low reset
user_btn  in  1  debounced button level, synchronous to clk_100MHz
out_ready  in  1  consumer accepts the record
out_valid  out  1  record held in output register
sym_data  out  MAX_SYMS  bit i = symbol i (1 = dash); bits >= sym_len are 0
sym_len  out  $clog2(MAX_SYMS+1)  symbol count; 0 for a space
is_space  out  1  record is a word space
overflow  out  1  char had more than MAX_SYMS valid symbols
abort  out  1  one-cycle pulse on an abort
drop  out  1  one-cycle pulse when a record is lost because the output is full

Behaviour:
- reset_n low (async): state IDLE; counters, buffer and len cleared; every output 0.
- press_cnt counts cycles with user_btn high while in PRESS. gap_cnt counts cycles since the last valid release and keeps running through glitches. Both saturate at all-ones.
- States and transitions:
  - IDLE: user_btn=1 -> PRESS.
  - PRESS: press_cnt reaches ABORT_UNITS*UNIT_CYC -> ABORT_WAIT.
  - PRESS, on the first low sample, classify L = press_cnt:
    - L < MIN_PRESS_CYC: glitch. Return to the originating state (IDLE, GAP or CHAR_WAIT); gap_cnt is not cleared.
    - L < DASH_UNITS*UNIT_CYC: append a dot, gap_cnt=1 -> GAP.
    - Otherwise: append a dash, gap_cnt=1 -> GAP.
  - GAP: user_btn=1 -> PRESS. gap_cnt reaches CHAR_GAP_UNITS*UNIT_CYC -> emit char record, clear buffer -> CHAR_WAIT.
  - CHAR_WAIT: user_btn=1 -> PRESS with an empty buffer. gap_cnt reaches WORD_GAP_UNITS*UNIT_CYC -> emit a space record if EMIT_SPACE, then IDLE.
  - ABORT_WAIT: on entry, pulse abort and clear buffer, len and ovf. On the first low sample -> IDLE with no record.
- Append rule: the symbol goes to bit sym_len and len increments. If len==MAX_SYMS, the symbol is discarded and ovf is set; ovf is reported in the char record and cleared after emission.
- Priority: user_btn=1 in the same cycle a gap threshold is reached means the press wins. No emission happens and the symbol joins the current char.
- Timing: out_valid rises exactly CHAR_GAP_UNITS*UNIT_CYC cycles after the first low sample of the last valid press. The space record follows after WORD_GAP_UNITS*UNIT_CYC cycles.
- Output handshake:
  - The record transfers on out_valid & out_ready, and out_valid falls next cycle unless a new record loads.
  - Record fields stay stable while out_valid=1 & out_ready=0.
  - New record while out_valid & !out_ready: the new record is discarded and drop pulses; the held record is unchanged.
  - New record while out_valid & out_ready in the same cycle: the new record loads with no drop.
- Reset mid-press or with out_valid=1: everything clears immediately, and the pending record is lost.

Test Plan:
All scenarios use UNIT_CYC=4, MIN_PRESS_CYC=2, defaults otherwise. Derived thresholds: dash>=8, abort>=40, char gap=12, word gap=28.
- Press 4 cycles, gap 4, press 10, gap 30, out_ready=1 -> char record sym_data=6'b000010, sym_len=2, is_space=0, overflow=0, 12 cycles after release. Space record sym_len=0, is_space=1 arrives 28 cycles after release.
- Press 1 cycle, then idle 40 -> no record, no abort, state stays IDLE. Same 1-cycle glitch mid-GAP -> char emitted on original gap timing.
- 7 dots (press 4, gap 4), out_ready=1 -> sym_data=6'b000000, sym_len=6, overflow=1.
- Dot, then press held 45 cycles -> abort pulses at cycle 40 of the press. No record on release. Next dash -> sym_len=1, sym_data bit0=1.
- out_ready=0: dot then gap 30 -> char held with out_valid=1. Space attempt at gap 28 -> drop pulse, char fields unchanged. Raise out_ready -> out_valid=0 next cycle.
- reset_n low for 1 cycle mid-press and again with out_valid=1 -> all outputs 0 asynchronously; subsequent dot decodes normally.

Source files
------------

// File: rtl/morse_rx_param_if.sv
`default_nettype none
// ============================================================================
// Module   : morse_rx_param_if
// Purpose  : Record channel from the Morse receiver to the character decoder.
//            One record is a completed character or a word space, held until
//            the consumer accepts it with out_valid & out_ready.
// Ports    : master = receiver side (drives the record, samples out_ready)
//            slave  = decoder side  (samples the record, drives out_ready)
//   out_valid  record present
//   out_ready  consumer accepts the record this cycle
//   sym_data   bit i = symbol i (1 = dash), bits >= sym_len are 0
//   sym_len    symbol count, 0 for a space record
//   is_space   record is a word space
//   overflow   character had more symbols than the buffer holds
// Revision : 1.0  initial release
// ============================================================================
interface morse_rx_param_if #(
  parameter int MAX_SYMS = 6
);
  localparam int LEN_W = $clog2(MAX_SYMS + 1);

  logic                out_valid;
  logic                out_ready;
  logic [MAX_SYMS-1:0] sym_data;
  logic [LEN_W-1:0]    sym_len;
  logic                is_space;
  logic                overflow;

  modport master (
    output out_valid, sym_data, sym_len, is_space, overflow,
    input  out_ready
  );

  modport slave (
    input  out_valid, sym_data, sym_len, is_space, overflow,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/morse_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : morse_rx_param
// Purpose  : Morse receiver. Classifies button presses (dot, dash, glitch,
//            abort) and gaps (intra-char, char end, word end) with internal
//            counters, and emits completed characters and word spaces through
//            a one-entry valid/ready output register.
// Ports    : clk_100MHz  clock
//            reset_n     asynchronous active-low reset
//            user_btn    debounced button level, synchronous to clk_100MHz
//            rec         record channel (master side, see morse_rx_param_if)
//            abort       one-cycle pulse when a long press aborts the char
//            drop        one-cycle pulse when a record is lost (output full)
// Revision : 1.0  initial release
// ============================================================================
module morse_rx_param #(
  parameter int UNIT_CYC       = 5000000,
  parameter int MIN_PRESS_CYC  = 100000,
  parameter int DASH_UNITS     = 2,
  parameter int ABORT_UNITS    = 10,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7,
  parameter int MAX_SYMS       = 6,
  parameter int EMIT_SPACE     = 1,
  parameter int CNT_W          = 32
) (
  input  wire logic        clk_100MHz,
  input  wire logic        reset_n,
  input  wire logic        user_btn,
  morse_rx_param_if.master rec,
  output logic             abort,
  output logic             drop
);

  localparam int LEN_W = $clog2(MAX_SYMS + 1);

  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_min_press = CNT_W'(MIN_PRESS_CYC);
  localparam logic [CNT_W-1:0] c_dash_cyc  = CNT_W'(DASH_UNITS * UNIT_CYC);
  localparam logic [CNT_W-1:0] c_abort_cyc = CNT_W'(ABORT_UNITS * UNIT_CYC);
  localparam logic [CNT_W-1:0] c_char_cyc  = CNT_W'(CHAR_GAP_UNITS * UNIT_CYC);
  localparam logic [CNT_W-1:0] c_word_cyc  = CNT_W'(WORD_GAP_UNITS * UNIT_CYC);
  localparam logic [LEN_W-1:0] c_max_len   = LEN_W'(MAX_SYMS);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRESS      = 3'd1,
    S_GAP        = 3'd2,
    S_CHAR_WAIT  = 3'd3,
    S_ABORT_WAIT = 3'd4
  } state_t;

  state_t              r_state;
  state_t              r_ret_state;   // where a glitch press returns to
  logic [CNT_W-1:0]    r_press_cnt;
  logic [CNT_W-1:0]    r_gap_cnt;
  logic [MAX_SYMS-1:0] r_sym_buf;
  logic [LEN_W-1:0]    r_sym_len;
  logic                r_ovf;

  logic                r_out_valid;
  logic [MAX_SYMS-1:0] r_out_data;
  logic [LEN_W-1:0]    r_out_len;
  logic                r_out_space;
  logic                r_out_ovf;
  logic                r_abort;
  logic                r_drop;

  logic [CNT_W-1:0]    w_press_inc;
  logic [CNT_W-1:0]    w_gap_inc;
  logic                w_is_dash;
  logic                w_buf_full;
  logic [MAX_SYMS-1:0] w_sym_buf_app;
  logic                w_emit_char;
  logic                w_emit_space;
  logic                w_emit;

  // Both counters saturate so a very long idle or press never wraps back
  // below a threshold.
  assign w_press_inc = (r_press_cnt == '1) ? r_press_cnt : r_press_cnt + 1'b1;
  assign w_gap_inc   = (r_gap_cnt == '1)   ? r_gap_cnt   : r_gap_cnt + 1'b1;

  assign w_is_dash  = (r_press_cnt >= c_dash_cyc);
  assign w_buf_full = (r_sym_len == c_max_len);

  // The new symbol lands at bit position sym_len.
  always_comb begin
    w_sym_buf_app = r_sym_buf;
    for (int i = 0; i < MAX_SYMS; i++) begin
      if (LEN_W'(i) == r_sym_len) begin
        w_sym_buf_app[i] = w_is_dash;
      end
    end
  end

  // A press sampled in the same cycle as a gap threshold wins: no emission.
  assign w_emit_char  = (r_state == S_GAP) && !user_btn && (r_gap_cnt >= c_char_cyc);
  assign w_emit_space = (EMIT_SPACE != 0) && (r_state == S_CHAR_WAIT) && !user_btn
                        && (r_gap_cnt >= c_word_cyc);
  assign w_emit       = w_emit_char || w_emit_space;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ret_state <= S_IDLE;
      r_press_cnt <= '0;
      r_gap_cnt   <= '0;
      r_sym_buf   <= '0;
      r_sym_len   <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_len   <= '0;
      r_out_space <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_abort     <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_abort   <= 1'b0;
      r_drop    <= 1'b0;
      // Free-running gap count; a valid release below restarts it at 1.
      r_gap_cnt <= w_gap_inc;

      case (r_state)
        S_IDLE: begin
          if (user_btn) begin
            r_state     <= S_PRESS;
            r_ret_state <= S_IDLE;
            r_press_cnt <= c_one;
          end
        end

        S_PRESS: begin
          if (user_btn) begin
            r_press_cnt <= w_press_inc;
            if (w_press_inc >= c_abort_cyc) begin
              r_state   <= S_ABORT_WAIT;
              r_abort   <= 1'b1;
              r_sym_buf <= '0;
              r_sym_len <= '0;
              r_ovf     <= 1'b0;
            end
          end else if (r_press_cnt < c_min_press) begin
            // Glitch: resume where we were, gap timing untouched.
            r_state <= r_ret_state;
          end else begin
            if (w_buf_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_sym_buf <= w_sym_buf_app;
              r_sym_len <= r_sym_len + 1'b1;
            end
            r_gap_cnt <= c_one;
            r_state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (user_btn) begin
            r_state     <= S_PRESS;
            r_ret_state <= S_GAP;
            r_press_cnt <= c_one;
          end else if (w_emit_char) begin
            r_sym_buf <= '0;
            r_sym_len <= '0;
            r_ovf     <= 1'b0;
            r_state   <= S_CHAR_WAIT;
          end
        end

        S_CHAR_WAIT: begin
          if (user_btn) begin
            r_state     <= S_PRESS;
            r_ret_state <= S_CHAR_WAIT;
            r_press_cnt <= c_one;
          end else if (r_gap_cnt >= c_word_cyc) begin
            r_state <= S_IDLE;
          end
        end

        S_ABORT_WAIT: begin
          if (!user_btn) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // One-entry output register. A record accepted this cycle frees the
      // slot, so a simultaneous new record loads instead of being dropped.
      if (r_out_valid && rec.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_emit) begin
        if (!r_out_valid || rec.out_ready) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_emit_space ? '0   : r_sym_buf;
          r_out_len   <= w_emit_space ? '0   : r_sym_len;
          r_out_space <= w_emit_space;
          r_out_ovf   <= w_emit_space ? 1'b0 : r_ovf;
        end else begin
          r_drop <= 1'b1;
        end
      end
    end
  end

  assign rec.out_valid = r_out_valid;
  assign rec.sym_data  = r_out_data;
  assign rec.sym_len   = r_out_len;
  assign rec.is_space  = r_out_space;
  assign rec.overflow  = r_out_ovf;
  assign abort         = r_abort;
  assign drop          = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_morse_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_rx_param
// Purpose  : Self-checking bench for morse_rx_param with UNIT_CYC=4 and
//            MIN_PRESS_CYC=2 (dash >= 8, abort >= 40, char gap 12, word 28).
// Revision : 1.0  initial release
// ============================================================================
module tb_morse_rx_param;

  localparam int MAX_SYMS = 6;

  typedef struct packed {
    logic [5:0] data;
    logic [2:0] len;
    logic       sp;
    logic       ovf;
  } rec_t;

  typedef struct packed {
    logic [3:0]      n;
    logic [6:0][5:0] plen;
    logic [5:0]      data;
    logic [2:0]      len;
    logic            ovf;
  } vec_t;

  logic clk_100MHz = 1'b0;
  logic reset_n    = 1'b0;
  logic user_btn   = 1'b0;
  logic abort;
  logic drop;

  int   n_tests   = 0;
  int   n_fail    = 0;
  int   abort_cnt = 0;
  int   drop_cnt  = 0;
  rec_t exp_q[$];
  rec_t mon_exp;
  vec_t vecs[8];

  always #5 clk_100MHz = ~clk_100MHz;

  morse_rx_param_if #(.MAX_SYMS(MAX_SYMS)) rx_if ();

  morse_rx_param #(
    .UNIT_CYC(4), .MIN_PRESS_CYC(2), .DASH_UNITS(2), .ABORT_UNITS(10),
    .CHAR_GAP_UNITS(3), .WORD_GAP_UNITS(7), .MAX_SYMS(MAX_SYMS),
    .EMIT_SPACE(1), .CNT_W(32)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .user_btn   (user_btn),
    .rec        (rx_if),
    .abort      (abort),
    .drop       (drop)
  );

  logic [13:0] outs;
  assign outs = {rx_if.out_valid, rx_if.sym_data, rx_if.sym_len,
                 rx_if.is_space, rx_if.overflow, abort, drop};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk_rec(logic [5:0] d, logic [2:0] l, logic sp, logic o);
    rec_t r;
    r.data = d; r.len = l; r.sp = sp; r.ovf = o;
    return r;
  endfunction

  function automatic vec_t mk(int n, int p0, int p1, int p2, int p3, int p4, int p5, int p6,
                              logic [5:0] d, logic [2:0] l, logic o);
    vec_t v;
    v.n = 4'(n);
    v.plen[0] = 6'(p0); v.plen[1] = 6'(p1); v.plen[2] = 6'(p2); v.plen[3] = 6'(p3);
    v.plen[4] = 6'(p4); v.plen[5] = 6'(p5); v.plen[6] = 6'(p6);
    v.data = d; v.len = l; v.ovf = o;
    return v;
  endfunction

  // Scoreboard: every accepted record is popped and compared.
  always @(negedge clk_100MHz) begin
    if (reset_n) begin
      if (abort) abort_cnt++;
      if (drop)  drop_cnt++;
      if (rx_if.out_valid && rx_if.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_record: actual 0x%0h required none",
                   {rx_if.sym_data, rx_if.sym_len, rx_if.is_space, rx_if.overflow});
        end else begin
          mon_exp = exp_q.pop_front();
          check("record", 32'({rx_if.sym_data, rx_if.sym_len, rx_if.is_space, rx_if.overflow}),
                32'(mon_exp));
        end
      end
    end
  end

  // Drive point: 2 time units after the active edge.
  task automatic tick();
    @(posedge clk_100MHz);
    #2;
  endtask

  task automatic idle(input int n);
    user_btn = 1'b0;
    repeat (n) tick();
  endtask

  task automatic press(input int n);
    user_btn = 1'b1;
    repeat (n) tick();
    user_btn = 1'b0;
  endtask

  // k counts active edges; k=1 is the first edge after the call.
  task automatic watch(input int k0, input int kmax,
                       output int kc, output int ks, output int ka, output int kd);
    kc = -1; ks = -1; ka = -1; kd = -1;
    for (int k = k0; k <= kmax; k++) begin
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      if (rx_if.out_valid && !rx_if.is_space && kc < 0) kc = k;
      if (rx_if.out_valid &&  rx_if.is_space && ks < 0) ks = k;
      if (abort && ka < 0) ka = k;
      if (drop  && kd < 0) kd = k;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int kc, ks, ka, kd, a0, d0;

    vecs[0] = mk(2, 4, 10, 0, 0, 0, 0, 0,    6'b000010, 3'd2, 1'b0);
    vecs[1] = mk(1, 8, 0, 0, 0, 0, 0, 0,     6'b000001, 3'd1, 1'b0);
    vecs[2] = mk(1, 7, 0, 0, 0, 0, 0, 0,     6'b000000, 3'd1, 1'b0);
    vecs[3] = mk(1, 2, 0, 0, 0, 0, 0, 0,     6'b000000, 3'd1, 1'b0);
    vecs[4] = mk(6, 10, 4, 10, 4, 10, 4, 0,  6'b010101, 3'd6, 1'b0);
    vecs[5] = mk(7, 4, 4, 4, 4, 4, 4, 4,     6'b000000, 3'd6, 1'b1);
    vecs[6] = mk(7, 10, 10, 10, 10, 10, 10, 4, 6'b111111, 3'd6, 1'b1);
    vecs[7] = mk(3, 4, 1, 10, 0, 0, 0, 0,    6'b000010, 3'd2, 1'b0);

    rx_if.out_ready = 1'b1;
    repeat (3) tick();
    check("reset_outputs", 32'(outs), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Table-driven characters, each followed by a word gap.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        press(int'(vecs[v].plen[i]));
        if (i < int'(vecs[v].n) - 1) idle(4);
      end
      exp_q.push_back(mk_rec(vecs[v].data, vecs[v].len, 1'b0, vecs[v].ovf));
      exp_q.push_back(mk_rec(6'd0, 3'd0, 1'b1, 1'b0));
      idle(32);
      check("vec_drain", 32'(exp_q.size()), 32'd0);
    end

    // Exact char and space latency after the last release.
    press(4); idle(4); press(10);
    exp_q.push_back(mk_rec(6'b000010, 3'd2, 1'b0, 1'b0));
    exp_q.push_back(mk_rec(6'd0, 3'd0, 1'b1, 1'b0));
    watch(1, 40, kc, ks, ka, kd);
    check("char_latency", 32'(kc), 32'd13);
    check("space_latency", 32'(ks), 32'd29);
    check("latency_drain", 32'(exp_q.size()), 32'd0);

    // Glitch from IDLE: nothing at all happens.
    tick();
    a0 = abort_cnt;
    press(1);
    watch(1, 40, kc, ks, ka, kd);
    check("glitch_idle_char", 32'(kc), 32'hffffffff);
    check("glitch_idle_space", 32'(ks), 32'hffffffff);
    check("glitch_idle_abort", 32'(abort_cnt - a0), 32'd0);

    // Glitch in GAP keeps the original char timing.
    tick();
    press(4);
    exp_q.push_back(mk_rec(6'b000000, 3'd1, 1'b0, 1'b0));
    exp_q.push_back(mk_rec(6'd0, 3'd0, 1'b1, 1'b0));
    idle(4); press(1);
    watch(6, 40, kc, ks, ka, kd);
    check("glitch_gap_latency", 32'(kc), 32'd13);
    check("glitch_gap_drain", 32'(exp_q.size()), 32'd0);

    // Abort: dot, then a held press.
    tick();
    press(4); idle(4);
    a0 = abort_cnt;
    user_btn = 1'b1;
    watch(1, 45, kc, ks, ka, kd);
    user_btn = 1'b0;
    check("abort_cycle", 32'(ka), 32'd40);
    check("abort_pulses", 32'(abort_cnt - a0), 32'd1);
    idle(32);
    press(10);
    exp_q.push_back(mk_rec(6'b000001, 3'd1, 1'b0, 1'b0));
    exp_q.push_back(mk_rec(6'd0, 3'd0, 1'b1, 1'b0));
    idle(32);
    check("abort_drain", 32'(exp_q.size()), 32'd0);

    // Back-pressure: held char, dropped space.
    rx_if.out_ready = 1'b0;
    tick();
    d0 = drop_cnt;
    press(4);
    watch(1, 35, kc, ks, ka, kd);
    check("held_char_latency", 32'(kc), 32'd13);
    check("drop_cycle", 32'(kd), 32'd29);
    check("drop_pulses", 32'(drop_cnt - d0), 32'd1);
    check("held_fields", 32'(outs), 32'({1'b1, 6'b000000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0}));
    exp_q.push_back(mk_rec(6'b000000, 3'd1, 1'b0, 1'b0));
    tick();
    rx_if.out_ready = 1'b1;
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    check("valid_fall", 32'(rx_if.out_valid), 32'd0);
    check("held_drain", 32'(exp_q.size()), 32'd0);
    idle(8);

    // Reset mid-press and with a held record.
    user_btn = 1'b1;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check("reset_mid_press", 32'(outs), 32'd0);
    tick();
    user_btn = 1'b0;
    reset_n  = 1'b1;
    rx_if.out_ready = 1'b0;
    press(4);
    idle(20);
    check("held_before_reset", 32'(rx_if.out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_held_record", 32'(outs), 32'd0);
    tick();
    reset_n = 1'b1;
    rx_if.out_ready = 1'b1;
    idle(2);
    press(4);
    exp_q.push_back(mk_rec(6'b000000, 3'd1, 1'b0, 1'b0));
    exp_q.push_back(mk_rec(6'd0, 3'd0, 1'b1, 1'b0));
    idle(32);
    check("after_reset_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
